ov7670_stream_capture: RTL and testbench

Parametrised camera-port capture engine for the OV7670 pixel bus. Assembles byte pairs into pixels, converts them per a run-time format mode, and optionally 2×2-decimates. Generates frame-buffer write address, data and strobe, tracks frame/line geometry with error flags, and arms/disarms capture on frame boundaries. Sits between the camera pins (pclk domain) and the frame-buffer RAM write port.

---
 rtl/ov7670_stream_capture_if.sv | 11 +
 rtl/ov7670_stream_capture.sv | 152 +++++++++++++++
 tb/tb_ov7670_stream_capture.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_stream_capture_if.sv
// rtl/ov7670_stream_capture_if.sv - frame-buffer write port (address, data, strobe)
interface ov7670_stream_capture_if #(
  parameter int ADDR_W = 19
);
  logic [ADDR_W-1:0] addr;
  logic [15:0]       dout;
  logic              we;

  modport master (output addr, output dout, output we);
  modport slave  (input addr, input dout, input we);
endinterface

// File: rtl/ov7670_stream_capture.sv
// rtl/ov7670_stream_capture.sv - OV7670 byte-pair capture, format conversion, optional 2x2 decimation, frame-buffer writes
module ov7670_stream_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                    pclk,
  input  logic                    reset_n,
  input  logic                    vsync,
  input  logic                    href,
  input  logic [7:0]              d,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic                    decim,
  ov7670_stream_capture_if.master fb,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              frame_cnt,
  output logic                    line_err,
  output logic                    frame_err
);
  localparam int CW = 16;
  localparam logic [CW-1:0]     H_LIM    = CW'(H_ACTIVE);
  localparam logic [CW-1:0]     V_LIM    = CW'(V_ACTIVE);
  localparam logic [CW-1:0]     CNT_MAX  = '1;
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] STRIDE_D = ADDR_W'(H_ACTIVE / 2);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SYNC, S_CAPTURE} state_t;

  state_t state, state_nxt;
  logic   capturing, start_frame, end_frame;

  logic              phase, had_byte, decim_q;
  logic [1:0]        mode_q;
  logic [7:0]        first_byte;
  logic [CW-1:0]     col, row;
  logic [ADDR_W-1:0] line_base;

  logic [15:0]   pixel, pix_data;
  logic [CW-1:0] col_idx, col_inc, row_inc, row_final;
  logic          row_end, wr_ok;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (enable) state_nxt = S_ARMED;
      S_ARMED:   if (vsync) state_nxt = S_SYNC;
                 else if (!enable) state_nxt = S_IDLE;
      S_SYNC:    if (!vsync) state_nxt = S_CAPTURE;
      S_CAPTURE: if (vsync) state_nxt = enable ? S_SYNC : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    capturing   = (state == S_CAPTURE);
    start_frame = (state == S_SYNC) && !vsync;
    end_frame   = capturing && vsync;
    busy        = (state == S_SYNC) || (state == S_CAPTURE);
  end

  // Counters saturate so an overlong line or frame can never wrap back into the write window.
  always_comb begin
    pixel     = {first_byte, d};
    col_inc   = (col == CNT_MAX) ? col : col + 1'b1;
    row_inc   = (row == CNT_MAX) ? row : row + 1'b1;
    row_end   = capturing && !href && had_byte;
    row_final = row_end ? row_inc : row;
    col_idx   = decim_q ? (col >> 1) : col;
    wr_ok     = (col < H_LIM) && (row < V_LIM) && !(decim_q && (col[0] || row[0]));
    case (mode_q)
      2'b01:   pix_data = pixel;
      2'b10:   pix_data = {4'h0, first_byte[7:4], first_byte[7:4], first_byte[7:4]};
      default: pix_data = {4'h0, pixel[15:12], pixel[10:7], pixel[4:1]};
    endcase
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      fb.addr    <= '0;
      fb.dout    <= '0;
      fb.we      <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      phase      <= 1'b0;
      had_byte   <= 1'b0;
      first_byte <= '0;
      col        <= '0;
      row        <= '0;
      line_base  <= '0;
      mode_q     <= '0;
      decim_q    <= 1'b0;
    end else begin
      fb.we      <= 1'b0;
      frame_done <= 1'b0;
      if (start_frame) begin
        mode_q    <= mode;
        decim_q   <= decim;
        col       <= '0;
        row       <= '0;
        line_base <= '0;
        line_err  <= 1'b0;
        frame_err <= 1'b0;
        phase     <= 1'b0;
        had_byte  <= 1'b0;
      end else if (capturing) begin
        if (href) begin
          had_byte <= 1'b1;
          phase    <= ~phase;
          if (!phase) begin
            first_byte <= d;
          end else begin
            col <= col_inc;
            if (wr_ok) begin
              fb.we   <= 1'b1;
              fb.addr <= line_base + ADDR_W'(col_idx);
              fb.dout <= pix_data;
            end
          end
        end else begin
          phase <= 1'b0;
          if (had_byte) begin
            // Line end: phase still 1 here means an odd byte count.
            had_byte <= 1'b0;
            col      <= '0;
            row      <= row_inc;
            if (!decim_q)     line_base <= line_base + STRIDE;
            else if (!row[0]) line_base <= line_base + STRIDE_D;
            if (col != H_LIM || phase) line_err <= 1'b1;
            if (row_inc > V_LIM) frame_err <= 1'b1;
          end
        end
        if (end_frame) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
          if (row_final != V_LIM) frame_err <= 1'b1;
        end
      end else begin
        phase    <= 1'b0;
        had_byte <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ov7670_stream_capture.sv
// tb/tb_ov7670_stream_capture.sv - randomized frames checked against a frame-level reference model
module tb_ov7670_stream_capture;
  localparam int H  = 4;
  localparam int V  = 4;
  localparam int AW = 4;

  logic       pclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vsync = 1'b0, href = 1'b0, enable = 1'b0, decim = 1'b0;
  logic [7:0] d = 8'h00;
  logic [1:0] mode = 2'b00;
  logic       busy, frame_done, line_err, frame_err;
  logic [7:0] frame_cnt;

  ov7670_stream_capture_if #(.ADDR_W(AW)) fb ();

  ov7670_stream_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk(pclk), .reset_n(reset_n), .vsync(vsync), .href(href), .d(d),
    .enable(enable), .mode(mode), .decim(decim), .fb(fb),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .line_err(line_err), .frame_err(frame_err)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] got_q[$];
  always @(negedge pclk) begin
    if (fb.we === 1'b1) got_q.push_back({16'(fb.addr), fb.dout});
  end

  int         nlines;
  int         nbytes[8];
  logic [7:0] lb[8][12];
  int         fc = 0;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic fill_line(input int l, input int npix, input bit odd, input bit rnd,
                           input logic [7:0] b0, input logic [7:0] b1);
    nbytes[l] = 2 * npix + (odd ? 1 : 0);
    for (int k = 0; k < 12; k++)
      lb[l][k] = rnd ? 8'($urandom) : ((k % 2 == 0) ? b0 : b1);
  endtask

  function automatic logic [15:0] conv_model(input int m, input int b0, input int b1);
    int r, g, b;
    if (m == 1) return 16'((b0 << 8) | b1);
    if (m == 2) return 16'((b0 >> 4) * 'h111);
    r = b0 >> 4;
    g = ((b0 & 7) << 1) | (b1 >> 7);
    b = (b1 >> 1) & 15;
    return 16'((r << 8) | (g << 4) | b);
  endfunction

  task automatic send_frame(input int m, input bit dc, input bit drop_en, input string name);
    logic [31:0] exp_q[$];
    int exp_le, np, a, n;
    got_q.delete();
    enable = 1'b1;
    vsync  = 1'b1;
    repeat (3) step();
    mode  = 2'(m);
    decim = dc;
    vsync = 1'b0;
    step();
    mode  = 2'($urandom);
    decim = 1'($urandom);
    @(negedge pclk);
    chk({name, ":start_busy"}, 32'(busy), 1);
    chk({name, ":start_lerr"}, 32'(line_err), 0);
    chk({name, ":start_ferr"}, 32'(frame_err), 0);
    for (int l = 0; l < nlines; l++) begin
      for (int k = 0; k < nbytes[l]; k++) begin
        step();
        href = 1'b1;
        d    = lb[l][k];
      end
      step();
      href = 1'b0;
      d    = 8'h00;
      if (drop_en && l == 0) enable = 1'b0;
      repeat (2) step();
    end
    if (nlines > V) chk({name, ":ferr_early"}, 32'(frame_err), 1);
    vsync = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    chk({name, ":fdone"}, 32'(frame_done), 1);
    @(negedge pclk);
    chk({name, ":fdone_pulse"}, 32'(frame_done), 0);

    exp_le = 0;
    for (int r = 0; r < nlines; r++) begin
      np = nbytes[r] / 2;
      if (np != H || (nbytes[r] % 2) != 0) exp_le = 1;
      for (int c = 0; c < np; c++) begin
        if (c < H && r < V && (!dc || (c % 2 == 0 && r % 2 == 0))) begin
          a = dc ? (r / 2) * (H / 2) + c / 2 : r * H + c;
          exp_q.push_back({a[15:0], conv_model(m & 3, lb[r][2*c], lb[r][2*c+1])});
        end
      end
    end
    fc = (fc + 1) % 256;

    chk({name, ":nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s:wr%0d", name, i), got_q[i], exp_q[i]);
    chk({name, ":fcnt"}, 32'(frame_cnt), 32'(fc));
    chk({name, ":lerr"}, 32'(line_err), 32'(exp_le));
    chk({name, ":ferr"}, 32'(frame_err), (nlines != V) ? 1 : 0);
    chk({name, ":busy_after"}, 32'(busy), drop_en ? 0 : 1);
    enable = 1'b1;
  endtask

  initial begin
    @(negedge pclk);
    chk("rst_we", 32'(fb.we), 0);
    chk("rst_addr", 32'(fb.addr), 0);
    chk("rst_dout", 32'(fb.dout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fcnt", 32'(frame_cnt), 0);
    chk("rst_errs", {30'd0, line_err, frame_err}, 0);
    step();
    reset_n = 1'b1;
    repeat (2) step();

    nlines = 4;
    for (int l = 0; l < 4; l++) fill_line(l, 4, 0, 0, 8'hF8, 8'h1F);
    send_frame(0, 0, 0, "rgb444");
    chk("rgb444_val", got_q.size() > 0 ? got_q[0][15:0] : 32'hDEAD, 32'h0F0F);

    for (int l = 0; l < 4; l++) fill_line(l, 4, 0, 0, 8'h12, 8'h34);
    send_frame(1, 0, 0, "raw");
    chk("raw_val", got_q.size() > 0 ? got_q[0][15:0] : 32'hDEAD, 32'h1234);

    for (int l = 0; l < 4; l++) fill_line(l, 4, 0, 0, 8'hA5, 8'h80);
    send_frame(2, 0, 0, "gray");
    chk("gray_val", got_q.size() > 0 ? got_q[0][15:0] : 32'hDEAD, 32'h0AAA);

    for (int l = 0; l < 4; l++) fill_line(l, 4, 0, 1, 0, 0);
    send_frame(1, 1, 0, "decim");

    fill_line(0, 3, 0, 1, 0, 0);
    for (int l = 1; l < 4; l++) fill_line(l, 4, 0, 1, 0, 0);
    send_frame(0, 0, 0, "short");

    nlines = 5;
    for (int l = 0; l < 5; l++) fill_line(l, 4, 0, 1, 0, 0);
    send_frame(1, 0, 0, "tall");

    nlines = 4;
    fill_line(0, 4, 0, 1, 0, 0);
    fill_line(1, 4, 1, 1, 0, 0);
    fill_line(2, 4, 0, 1, 0, 0);
    fill_line(3, 4, 0, 1, 0, 0);
    send_frame(1, 0, 0, "oddbytes");

    for (int l = 0; l < 4; l++) fill_line(l, 4, 0, 1, 0, 0);
    send_frame(1, 0, 1, "drop_en");

    for (int f = 0; f < 6; f++) begin
      nlines = $urandom_range(3, 5);
      for (int l = 0; l < nlines; l++)
        fill_line(l, $urandom_range(2, 5), ($urandom_range(0, 4) == 0), 1, 0, 0);
      send_frame($urandom_range(0, 3), 1'($urandom), 0, $sformatf("rnd%0d", f));
    end

    vsync = 1'b1;
    repeat (3) step();
    vsync = 1'b0;
    repeat (2) step();
    href = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      step();
    end
    reset_n = 1'b0;
    @(negedge pclk);
    chk("mid_rst_we", 32'(fb.we), 0);
    chk("mid_rst_addr", 32'(fb.addr), 0);
    chk("mid_rst_dout", 32'(fb.dout), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_fcnt", 32'(frame_cnt), 0);
    chk("mid_rst_errs", {30'd0, line_err, frame_err}, 0);
    href = 1'b0;
    vsync = 1'b0;
    step();
    reset_n = 1'b1;
    fc = 0;
    step();

    nlines = 4;
    for (int l = 0; l < 4; l++) fill_line(l, 4, 0, 1, 0, 0);
    send_frame(0, 0, 0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
